// File: rtl/mm_pkg.sv
// Shared types for the matrix-multiplier result collector: FSM states and the
// per-bank frame descriptor.
package mm_pkg;

  localparam int unsigned MM_MAXE = 16;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_CAP   = 2'd1,
    C_DROP  = 2'd2,
    C_CLOSE = 2'd3
  } cap_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_SEND = 1'b1
  } drn_state_t;

  typedef struct packed {
    logic [2:0] rows;
    logic [2:0] cols;
    logic       err;
    logic [2:0] ep;
  } mm_desc_t;

  function automatic logic [2:0] sat3(input logic [5:0] v);
    return (v > 6'd7) ? 3'd7 : v[2:0];
  endfunction

endpackage

// File: rtl/mm_frame_bank.sv
// Two-bank frame store: one write port, one asynchronous read port, plus a
// full flag and a frame descriptor per bank.
module mm_frame_bank
  import mm_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned MAXE = MM_MAXE,
  parameter int unsigned AW   = $clog2(MAXE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output mm_desc_t      rd_desc,
  input  logic          set_en,
  input  logic          set_bank,
  input  mm_desc_t      set_desc,
  input  logic          clr_en,
  input  logic          clr_bank,
  output logic [1:0]    full
);

  logic [DW-1:0] mem  [2][MAXE];
  mm_desc_t      desc [2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
  end

  // Set and clear never target the same bank: set only hits an empty bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full    <= '0;
      desc[0] <= '0;
      desc[1] <= '0;
    end else begin
      if (set_en) begin
        full[set_bank] <= 1'b1;
        desc[set_bank] <= set_desc;
      end
      if (clr_en) full[clr_bank] <= 1'b0;
    end
  end

  assign rd_data = mem[rd_bank][rd_addr];
  assign rd_desc = desc[rd_bank];

endmodule

// File: rtl/mm_result_collector.sv
// Captures multiplier result frames into a double buffer and re-emits each
// frame on a ready/valid stream with row/frame delimiters and an error flag.
module mm_result_collector
  import mm_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned MAXE = MM_MAXE,
  parameter int unsigned DCW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  mm_data,
  input  logic           mm_valid,
  input  logic           mm_row_last,
  input  logic [2:0]     mm_ep,
  input  logic           mm_busy,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [DW-1:0]  o_data,
  output logic           o_row_last,
  output logic           o_frame_last,
  output logic           o_err,
  output logic [2:0]     o_rows,
  output logic [2:0]     o_cols,
  output logic [DCW-1:0] drop_cnt,
  output logic           ovf
);

  localparam int unsigned AW = $clog2(MAXE);
  localparam logic [AW:0] MAXE_W = (AW+1)'(MAXE);

  cap_state_t    cstate, cstate_nxt;
  logic          wr_sel, busy_q, drop_r;
  logic [AW:0]   idx, idx_cur, idx_nxt;
  logic [2:0]    rows_r, cols_r, rows_cur, cols_cur, rows_nxt, cols_nxt;
  logic [2:0]    ep_r, ep_cur, ep_nxt;
  logic          col_set, col_set_cur, col_set_nxt;
  logic          err_r, err_cur, err_nxt;
  logic          fall, frame_start, cap_active, accept, is_err, store, ovf_hit;
  logic          close_set;
  mm_desc_t      close_desc;
  logic [1:0]    full;

  drn_state_t    dstate;
  logic          rd_sel;
  logic [AW-1:0] k;
  logic [2:0]    ccnt;
  mm_desc_t      rd_desc;
  logic [DW-1:0] rd_data;
  logic [5:0]    total, kp1;
  logic          k_last, row_last, hs, drain_done;

  assign fall        = busy_q & ~mm_busy;
  assign frame_start = (cstate == C_IDLE) && mm_valid;
  assign cap_active  = (cstate == C_CAP) || (frame_start && !full[wr_sel]);
  assign close_set   = (cstate == C_CLOSE) && !drop_r;

  // In C_IDLE the per-frame registers hold stale values; the first entry is
  // processed against zeroed "current" values so it can be written immediately.
  always_comb begin
    idx_cur     = (cstate == C_IDLE) ? '0 : idx;
    rows_cur    = (cstate == C_IDLE) ? '0 : rows_r;
    cols_cur    = (cstate == C_IDLE) ? '0 : cols_r;
    col_set_cur = (cstate == C_IDLE) ? 1'b0 : col_set;
    err_cur     = (cstate == C_IDLE) ? 1'b0 : err_r;
    ep_cur      = (cstate == C_IDLE) ? '0 : ep_r;
    accept      = cap_active && mm_valid;
    is_err      = accept && (mm_ep != 3'd0);
    store       = accept && !is_err && (idx_cur < MAXE_W);
    ovf_hit     = accept && !is_err && (idx_cur == MAXE_W);
    idx_nxt     = idx_cur + {{AW{1'b0}}, store};
    rows_nxt    = rows_cur;
    cols_nxt    = cols_cur;
    col_set_nxt = col_set_cur;
    if (store && mm_row_last) begin
      rows_nxt = sat3({3'b0, rows_cur} + 6'd1);
      if (!col_set_cur) begin
        cols_nxt    = sat3(6'(idx_cur) + 6'd1);
        col_set_nxt = 1'b1;
      end
    end
    err_nxt = err_cur | is_err;
    ep_nxt  = is_err ? mm_ep : ep_cur;
  end

  always_comb begin
    cstate_nxt = cstate;
    case (cstate)
      C_IDLE:         if (mm_valid) cstate_nxt = fall ? C_CLOSE : (full[wr_sel] ? C_DROP : C_CAP);
      C_CAP, C_DROP:  if (fall) cstate_nxt = C_CLOSE;
      C_CLOSE:        cstate_nxt = C_IDLE;
      default:        cstate_nxt = C_IDLE;
    endcase
  end

  always_comb begin
    close_desc     = '0;
    close_desc.err = err_r;
    close_desc.ep  = ep_r;
    if (!err_r) begin
      close_desc.rows = rows_r;
      close_desc.cols = cols_r;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cstate   <= C_IDLE;
      wr_sel   <= 1'b0;
      busy_q   <= 1'b0;
      drop_r   <= 1'b0;
      idx      <= '0;
      rows_r   <= '0;
      cols_r   <= '0;
      col_set  <= 1'b0;
      err_r    <= 1'b0;
      ep_r     <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      busy_q <= mm_busy;
      cstate <= cstate_nxt;
      if (cap_active) begin
        idx     <= idx_nxt;
        rows_r  <= rows_nxt;
        cols_r  <= cols_nxt;
        col_set <= col_set_nxt;
        err_r   <= err_nxt;
        ep_r    <= ep_nxt;
      end
      if (frame_start) begin
        drop_r <= full[wr_sel];
        if (full[wr_sel] && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
      if (ovf_hit) ovf <= 1'b1;
      if (close_set) wr_sel <= ~wr_sel;
    end
  end

  mm_frame_bank #(
    .DW  (DW),
    .MAXE(MAXE),
    .AW  (AW)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (store),
    .wr_bank (wr_sel),
    .wr_addr (idx_cur[AW-1:0]),
    .wr_data (mm_data),
    .rd_bank (rd_sel),
    .rd_addr (k),
    .rd_data (rd_data),
    .rd_desc (rd_desc),
    .set_en  (close_set),
    .set_bank(wr_sel),
    .set_desc(close_desc),
    .clr_en  (drain_done),
    .clr_bank(rd_sel),
    .full    (full)
  );

  assign total      = {3'b0, rd_desc.rows} * {3'b0, rd_desc.cols};
  assign kp1        = 6'(k) + 6'd1;
  assign k_last     = rd_desc.err || (kp1 >= total) || (k == AW'(MAXE - 1));
  assign row_last   = rd_desc.err || (ccnt == rd_desc.cols - 3'd1);
  assign hs         = o_valid && o_ready;
  assign drain_done = hs && k_last;

  assign o_valid      = (dstate == D_SEND);
  assign o_data       = !o_valid ? '0 :
                        rd_desc.err ? {{(DW-3){1'b0}}, rd_desc.ep} : rd_data;
  assign o_row_last   = o_valid && row_last;
  assign o_frame_last = o_valid && k_last;
  assign o_err        = o_valid && rd_desc.err;
  assign o_rows       = o_valid ? rd_desc.rows : '0;
  assign o_cols       = o_valid ? rd_desc.cols : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dstate <= D_IDLE;
      rd_sel <= 1'b0;
      k      <= '0;
      ccnt   <= '0;
    end else begin
      case (dstate)
        D_IDLE: begin
          if (full[rd_sel]) begin
            dstate <= D_SEND;
            k      <= '0;
            ccnt   <= '0;
          end
        end
        D_SEND: begin
          if (hs) begin
            if (k_last) begin
              dstate <= D_IDLE;
              rd_sel <= ~rd_sel;
            end else begin
              k    <= k + 1'b1;
              ccnt <= row_last ? 3'd0 : ccnt + 3'd1;
            end
          end
        end
        default: dstate <= D_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_result_collector.sv
// Directed bench for mm_result_collector with a frame-level expected-beat model.
module tb_mm_result_collector;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] mm_data = '0;
  logic          mm_valid = 1'b0;
  logic          mm_row_last = 1'b0;
  logic [2:0]    mm_ep = '0;
  logic          mm_busy = 1'b0;
  logic          o_valid, o_ready, o_row_last, o_frame_last, o_err;
  logic [DW-1:0] o_data;
  logic [2:0]    o_rows, o_cols;
  logic [7:0]    drop_cnt;
  logic          ovf;

  mm_result_collector #(.DW(32), .MAXE(16), .DCW(8)) dut (
    .clk(clk), .rst(rst), .mm_data(mm_data), .mm_valid(mm_valid),
    .mm_row_last(mm_row_last), .mm_ep(mm_ep), .mm_busy(mm_busy),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_row_last(o_row_last), .o_frame_last(o_frame_last), .o_err(o_err),
    .o_rows(o_rows), .o_cols(o_cols), .drop_cnt(drop_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          rl, fl, err;
    logic [2:0]    rows, cols;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] got_q[$];
  int            checks = 0, errors = 0;
  int            outstanding = 0, model_drops = 0;
  logic [2:0]    last_rows, last_cols;
  logic          last_err;
  logic [DW-1:0] fdata [17];
  logic          frl   [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, $signed(act), $signed(req));
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Frame-level model: stores up to 16 entries, derives dims from row_last
  // pulses, and emits the row-major beat list.
  task automatic model_frame(input int n, input logic [2:0] ep);
    beat_t b;
    int stored, rows, cols;
    if (ep != 0) begin
      b.data = {29'b0, ep}; b.rl = 1; b.fl = 1; b.err = 1; b.rows = 0; b.cols = 0;
      exp_q.push_back(b);
    end else begin
      stored = (n > 16) ? 16 : n;
      rows = 0; cols = 0;
      for (int i = 0; i < stored; i++)
        if (frl[i]) begin
          rows++;
          if (cols == 0) cols = i + 1;
        end
      for (int kk = 0; kk < rows * cols; kk++) begin
        b.data = fdata[kk]; b.rl = ((kk + 1) % cols) == 0; b.fl = (kk == rows * cols - 1);
        b.err = 0; b.rows = 3'(rows); b.cols = 3'(cols);
        exp_q.push_back(b);
      end
    end
    outstanding++;
  endtask

  task automatic send_frame(input int n, input logic [2:0] ep);
    bit drop;
    drop = (outstanding >= 2);
    tick(); mm_busy = 1'b1; tick();
    for (int i = 0; i < n; i++) begin
      mm_valid = 1'b1; mm_data = fdata[i]; mm_row_last = frl[i];
      mm_ep = (i == 0) ? ep : 3'd0;
      tick();
    end
    mm_valid = 1'b0; mm_row_last = 1'b0; mm_ep = '0;
    tick(); mm_busy = 1'b0;
    if (drop) model_drops++;
    else model_frame(n, ep);
    repeat (4) tick();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100; i++) begin
      if (o_valid) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL wait_valid: o_valid=0 required 1 within 100 cycles");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) begin
        repeat (3) @(negedge clk);
        check("idle_after_drain", 32'(o_valid), 0);
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL drain_timeout: %0d beats left required 0", exp_q.size());
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 17; i++) begin fdata[i] = '0; frl[i] = 1'b0; end
  endtask

  // Per-cycle compare of every accepted beat plus hold-stability under stall.
  initial begin : compare
    beat_t e;
    logic pv, pr, prl, pfl, perr;
    logic [DW-1:0] pd;
    pv = 0; pr = 0; prl = 0; pfl = 0; perr = 0; pd = '0;
    forever begin
      @(negedge clk);
      if (!rst) pv = 0;
      else begin
        if (pv && !pr) begin
          checks++;
          if (!o_valid || o_data !== pd || o_row_last !== prl || o_frame_last !== pfl || o_err !== perr) begin
            errors++;
            $display("FAIL hold_stable: valid=%0b data=%0d required valid=1 data=%0d",
                     o_valid, $signed(o_data), $signed(pd));
          end
        end
        if (o_valid && o_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: data=%0d required no beat", $signed(o_data));
          end else begin
            e = exp_q.pop_front();
            if (o_data !== e.data || o_row_last !== e.rl || o_frame_last !== e.fl ||
                o_err !== e.err || o_rows !== e.rows || o_cols !== e.cols) begin
              errors++;
              $display("FAIL beat: data=%0d rl=%0b fl=%0b err=%0b rows=%0d cols=%0d required data=%0d rl=%0b fl=%0b err=%0b rows=%0d cols=%0d",
                       $signed(o_data), o_row_last, o_frame_last, o_err, o_rows, o_cols,
                       $signed(e.data), e.rl, e.fl, e.err, e.rows, e.cols);
            end
            if (e.fl) outstanding--;
          end
          got_q.push_back(o_data);
          last_rows = o_rows; last_cols = o_cols; last_err = o_err;
        end
        pv = o_valid; pr = o_ready; pd = o_data; prl = o_row_last; pfl = o_frame_last; perr = o_err;
      end
    end
  end

  initial begin
    o_ready = 1'b1;
    clear_frame();
    repeat (3) tick();
    check("rst_valid", 32'(o_valid), 0);
    check("rst_data", o_data, 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    check("rst_ovf", 32'(ovf), 0);
    rst = 1'b1;
    repeat (2) tick();

    // 2x2 frame
    clear_frame();
    fdata[0] = 5; fdata[1] = -6; fdata[2] = 7; fdata[3] = 8; frl[1] = 1; frl[3] = 1;
    got_q.delete();
    send_frame(4, 3'd0);
    wait_drain();
    check("f2x2_count", 32'(got_q.size()), 4);
    if (got_q.size() == 4) begin
      check("f2x2_b0", got_q[0], 5);
      check("f2x2_b1", got_q[1], -6);
      check("f2x2_b3", got_q[3], 8);
    end
    check("f2x2_rows", 32'(last_rows), 2);
    check("f2x2_cols", 32'(last_cols), 2);

    // error frame
    clear_frame();
    fdata[0] = 99;
    got_q.delete();
    send_frame(1, 3'd3);
    wait_drain();
    check("err_count", 32'(got_q.size()), 1);
    if (got_q.size() == 1) check("err_data", got_q[0], 3);
    check("err_flag", 32'(last_err), 1);
    check("err_rows", 32'(last_rows), 0);

    // backpressure on a 1x3 frame
    clear_frame();
    fdata[0] = 1; fdata[1] = 2; fdata[2] = 3; frl[2] = 1;
    o_ready = 1'b0;
    got_q.delete();
    send_frame(3, 3'd0);
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(o_valid), 1);
      check("bp_hold_data", o_data, 1);
    end
    @(posedge clk); #1 o_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_consec_valid", 32'(o_valid), 1);
      check("bp_consec_data", o_data, 32'(i + 1));
    end
    wait_drain();

    // three 1x1 frames with the sink stalled: third is dropped
    o_ready = 1'b0;
    got_q.delete();
    for (int f = 0; f < 3; f++) begin
      clear_frame();
      fdata[0] = 32'((f + 1) * 10); frl[0] = 1;
      send_frame(1, 3'd0);
    end
    check("drop_cnt_lit", 32'(drop_cnt), 1);
    check("drop_cnt_model", 32'(drop_cnt), 32'(model_drops));
    tick(); o_ready = 1'b1;
    wait_drain();
    check("drop_count", 32'(got_q.size()), 2);
    if (got_q.size() == 2) begin
      check("drop_b0", got_q[0], 10);
      check("drop_b1", got_q[1], 20);
    end

    // 17 entries: overflow, 16 kept, 4x4 from row_last pulses
    clear_frame();
    for (int i = 0; i < 17; i++) fdata[i] = 32'(100 + i);
    frl[3] = 1; frl[7] = 1; frl[11] = 1; frl[15] = 1;
    got_q.delete();
    check("ovf_before", 32'(ovf), 0);
    send_frame(17, 3'd0);
    check("ovf_set", 32'(ovf), 1);
    wait_drain();
    check("ovf_count", 32'(got_q.size()), 16);
    if (got_q.size() == 16) check("ovf_last", got_q[15], 115);
    check("ovf_rows", 32'(last_rows), 4);
    check("ovf_cols", 32'(last_cols), 4);

    // reset in the middle of draining a 4x4 frame
    clear_frame();
    for (int i = 0; i < 16; i++) fdata[i] = 32'(200 + i);
    frl[3] = 1; frl[7] = 1; frl[11] = 1; frl[15] = 1;
    o_ready = 1'b0;
    send_frame(16, 3'd0);
    wait_valid();
    @(posedge clk); #1 o_ready = 1'b1;
    tick(); tick(); o_ready = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    check("rst_mid_valid", 32'(o_valid), 0);
    check("rst_mid_drop_cnt", 32'(drop_cnt), 0);
    check("rst_mid_ovf", 32'(ovf), 0);
    exp_q.delete();
    outstanding = 0;
    tick(); tick();
    rst = 1'b1;
    tick();
    clear_frame();
    fdata[0] = 42; fdata[1] = -1; frl[1] = 1;
    o_ready = 1'b1;
    got_q.delete();
    send_frame(2, 3'd0);
    wait_drain();
    check("post_rst_count", 32'(got_q.size()), 2);
    if (got_q.size() == 2) begin
      check("post_rst_b0", got_q[0], 42);
      check("post_rst_b1", got_q[1], -1);
    end
    check("post_rst_cols", 32'(last_cols), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mm_result_collector.md
Name: mm_result_collector

Overview:
- Downstream stage of the three-matrix multiplier. Captures its streamed results (out_data, valid, change_row, ep, busy) into a frame buffer, one product matrix per frame.
- Re-emits each frame on a ready/valid stream with row and frame delimiters and an error flag.
- The multiplier has no backpressure. This block therefore double-buffers whole frames and drops a frame only when both banks are occupied.

Parameters:
- DW, 32, result data width; matches the multiplier's out_data.
- MAXE, 16, entries per bank (max 4x4 result).
- DCW, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- mm_data  in  DW  signed result word from the multiplier.
- mm_valid  in  1  mm_data/mm_ep qualifier, sampled each rising edge.
- mm_row_last  in  1  high with mm_valid on the last entry of a result row.
- mm_ep  in  3  error code; non-zero with mm_valid marks an illegal-operation frame.
- mm_busy  in  1  multiplier busy; a 1->0 transition closes the current frame.
- o_valid  out  1  output beat valid.
- o_ready  in  1  downstream ready.
- o_data  out  DW  result entry, or {29'b0, ep} for an error frame.
- o_row_last  out  1  last entry of a row.
- o_frame_last  out  1  last entry of the frame.
- o_err  out  1  beat belongs to an error frame.
- o_rows  out  3  row count of the frame being emitted (0 for error frames).
- o_cols  out  3  column count of the frame being emitted (0 for error frames).
- drop_cnt  out  DCW  frames dropped, saturating.
- ovf  out  1  sticky: a frame exceeded MAXE entries; cleared only by reset.

Behaviour:
- Reset (rst=0, async): all outputs 0, both banks empty, wr_sel=rd_sel=0, capture FSM in C_IDLE, drain FSM in D_IDLE. Reset mid-frame or mid-drain discards all buffered data.
- Capture FSM states: C_IDLE, C_CAP, C_DROP, C_CLOSE.
  - C_IDLE -> C_CAP on mm_valid when bank[wr_sel] is empty. The first entry is written in that same cycle.
  - C_IDLE -> C_DROP on mm_valid when bank[wr_sel] is full. drop_cnt increments, saturating at 2^DCW-1.
  - C_CAP: every mm_valid writes entry idx to bank[wr_sel] and increments idx.
  - Column count = idx+1 at the first mm_row_last. Row count = number of mm_row_last pulses.
  - idx reaching MAXE: further entries are ignored and ovf is set.
  - mm_valid with mm_ep!=0: frame marked error and ep stored. Entry data is ignored; rows=cols=0.
  - C_CAP/C_DROP -> C_CLOSE on the first cycle mm_busy is 0 after being 1 (registered falling-edge detect).
  - C_CLOSE (1 cycle): if not dropped, set full[wr_sel], latch dims/err/ep into the bank, toggle wr_sel. Then -> C_IDLE.
  - An error frame with no data entries still closes normally.
- Drain FSM states: D_IDLE, D_SEND.
  - D_IDLE -> D_SEND when full[rd_sel]=1. o_valid rises the cycle after full is set, so the first beat appears 2 cycles after the mm_busy falling edge is sampled.
  - D_SEND, normal frame: beats are entries 0..rows*cols-1 in row-major order.
    - o_row_last when (k+1)%cols==0.
    - o_frame_last on k=rows*cols-1.
  - D_SEND, error frame: exactly one beat, o_data={29'b0,ep}, o_err=1, o_row_last=o_frame_last=1.
  - Beat k advances only when o_valid&&o_ready. o_data and flags stay stable while o_valid=1 and o_ready=0.
  - Handshake on the frame_last beat: clear full[rd_sel], toggle rd_sel, then -> D_IDLE. If the other bank is already full, o_valid may deassert for one cycle before the next frame.
- Simultaneous events:
  - C_CLOSE filling one bank and the drain freeing the other in the same cycle: both updates apply.
  - A new frame starting in the same cycle its target bank is freed sees it full and is dropped. Full status is the registered value.
- Arithmetic: no data arithmetic is performed; data passes through unmodified, sign preserved. o_rows and o_cols are 1..4 for normal frames.

Decomposition:
- Shared package mm_pkg:
  - constant MM_MAXE=16;
  - capture-state enum (C_IDLE, C_CAP, C_DROP, C_CLOSE);
  - drain-state enum (D_IDLE, D_SEND);
  - frame-descriptor struct {rows[2:0], cols[2:0], err, ep[2:0]}.
- Sub-module mm_frame_bank: 2xMAXE xDW storage with one write port and one read port, plus per-bank full flag and descriptor register.

Test Plan:
- 2x2 frame 5,-6,7,8 with row_last on entries 2 and 4, busy falls, o_ready=1 -> beats 5,-6,7,8; row_last on beats 2,4; frame_last on beat 4; o_rows=o_cols=2; o_err=0.
- Error frame: one mm_valid with mm_ep=3, busy falls -> single beat, o_data=3, o_err=1, o_row_last=o_frame_last=1, o_rows=o_cols=0.
- Backpressure: 1x3 frame 1,2,3 with o_ready held low for 5 cycles -> o_valid=1, o_data=1 held stable; then 1,2,3 in consecutive cycles once o_ready=1.
- Three 1x1 frames (10, 20, 30) with o_ready=0 throughout -> the third frame is dropped, drop_cnt=1; after o_ready=1, outputs are 10, 20 only.
- 17 entries in one frame -> ovf=1, exactly 16 entries stored; dims reflect the row_last pulses received.
- Reset asserted during D_SEND of a 4x4 frame -> o_valid=0 immediately, drop_cnt=0; the next frame is emitted correctly from bank 0.
